// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg -- shared definitions for the instruction fetch stage.
//   fetch_state_e    : fetch FSM states (REQ, RESP, DROP)
//   RESET_PC_DEFAULT : default fetch address after reset
// -----------------------------------------------------------------------------
package rv_pkg;

  // REQ  : may issue a request at pc
  // RESP : waiting for the response of a live request
  // DROP : waiting for the response of a request made stale by a redirect
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    RESP = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : rv_pkg

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder -- plain combinational adder, sum wraps modulo 2^WIDTH.
//   a_i, b_i : operands
//   cin_i    : carry in
//   sum_o    : a_i + b_i + cin_i (truncated to WIDTH bits)
// -----------------------------------------------------------------------------
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i + {{(WIDTH-1){1'b0}}, cin_i};

endmodule : adder

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a single-entry fetch buffer and at
// most one outstanding instruction-memory request.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   taken_i, target_i   : redirect from EX (branch taken / jal / jalr)
//   stall_i             : decode stall, holds the fetch buffer
//   imem_req_o/addr_o   : instruction memory request and address
//   imem_gnt_i          : request accepted this cycle
//   imem_rvalid_i/rdata_i : response valid and instruction
//   if_valid_o/pc_o/instr_o : fetch buffer contents
//   flush_o             : kill IF/ID and ID/EX (same cycle as taken_i)
//   misalign_o          : only with IF_MISALIGN_CHK_EN; one-cycle registered
//                         pulse after a redirect to a non word-aligned target
//
// Build option: define IF_MISALIGN_CHK_EN to enable the misalignment check;
// redirect targets then have bits [1:0] cleared.
// -----------------------------------------------------------------------------
module if_fetch
  import rv_pkg::*;
#(
  parameter int                    DATA_WITDH = 32,
  parameter logic [DATA_WITDH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  taken_i,
  input  logic [DATA_WITDH-1:0] target_i,
  input  logic                  stall_i,
  output logic                  imem_req_o,
  output logic [DATA_WITDH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WITDH-1:0] imem_rdata_i,
  output logic                  if_valid_o,
  output logic [DATA_WITDH-1:0] if_pc_o,
  output logic [DATA_WITDH-1:0] if_instr_o,
`ifdef IF_MISALIGN_CHK_EN
  output logic                  misalign_o,
`endif
  output logic                  flush_o
);

  fetch_state_e          state_q;
  logic [DATA_WITDH-1:0] pc_q;
  logic [DATA_WITDH-1:0] req_pc_q;
  logic                  valid_q;
  logic [DATA_WITDH-1:0] buf_pc_q;
  logic [DATA_WITDH-1:0] buf_instr_q;

  logic [DATA_WITDH-1:0] pc_plus4;
  logic [DATA_WITDH-1:0] target_eff;
  logic                  fetch_fire;

  adder #(.WIDTH(DATA_WITDH)) u_pc_inc (
    .a_i   (pc_q),
    .b_i   (DATA_WITDH'(4)),
    .cin_i (1'b0),
    .sum_o (pc_plus4)
  );

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;

  assign target_eff = {target_i[DATA_WITDH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= taken_i && (target_i[1:0] != 2'b00);
  end

  assign misalign_o = misalign_q;
`else
  assign target_eff = target_i;
`endif

  // A full buffer that decode is stalling on blocks new requests; a buffer
  // being consumed this cycle may be refilled by the request issued now.
  assign imem_req_o  = (state_q == REQ) && !(valid_q && stall_i);
  assign imem_addr_o = pc_q;
  assign fetch_fire  = imem_req_o && imem_gnt_i;
  assign flush_o     = taken_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      valid_q     <= 1'b0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments; later assignments in this block
      // override earlier ones, which is how the redirect gets priority below.
      if (valid_q && !stall_i) valid_q <= 1'b0;

      case (state_q)
        REQ: begin
          if (fetch_fire) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_plus4;
            // A redirect in the grant cycle leaves an old-PC request in flight.
            state_q  <= taken_i ? DROP : RESP;
          end
        end
        RESP: begin
          if (imem_rvalid_i) begin
            state_q <= REQ;
            if (!taken_i) begin
              buf_pc_q    <= req_pc_q;
              buf_instr_q <= imem_rdata_i;
              valid_q     <= 1'b1;
            end
          end else if (taken_i) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          // Stale response is discarded; the buffer is left untouched.
          if (imem_rvalid_i) state_q <= REQ;
        end
        default: state_q <= REQ;
      endcase

      if (taken_i) begin
        pc_q    <= target_eff;
        valid_q <= 1'b0;
      end
    end
  end

  assign if_valid_o = valid_q;
  assign if_pc_o    = buf_pc_q;
  assign if_instr_o = buf_instr_q;

endmodule : if_fetch

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch. A transaction-level model
// (outstanding request + live flag + buffer) predicts every output; directed
// scenarios are followed by randomized traffic. Honors IF_MISALIGN_CHK_EN.
// -----------------------------------------------------------------------------
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        taken_i;
  logic [31:0] target_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        flush_o;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  if_fetch #(.DATA_WITDH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .taken_i       (taken_i),
    .target_i      (target_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
`ifdef IF_MISALIGN_CHK_EN
    .misalign_o    (misalign_o),
`endif
    .flush_o       (flush_o)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: where fetch will go next, whether a request is in flight
  // and whether its response is still wanted, and the buffer contents.
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_live;
  logic [31:0] m_out_pc;
  bit          m_valid;
  logic [31:0] m_bpc;
  logic [31:0] m_binstr;
  bit          m_mis;

  // Values seen just before the most recent active edge.
  logic        obs_req;
  logic [31:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_target(input logic [31:0] t);
`ifdef IF_MISALIGN_CHK_EN
    return {t[31:2], 2'b00};
`else
    return t;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_live = 0; m_out_pc = 32'h0;
    m_valid = 0; m_bpc = 32'h0; m_binstr = 32'h0; m_mis = 0;
  endtask

  // One clock cycle: drive inputs, check the combinational outputs, advance
  // the model across the edge, then check the registered outputs.
  task automatic step(input bit r, input bit tk, input logic [31:0] tg,
                      input bit st, input bit gn, input bit rv);
    bit exp_req, fire, resp;
    @(negedge clk);
    rst = r; taken_i = tk; target_i = tg; stall_i = st;
    imem_gnt_i = gn; imem_rvalid_i = rv; imem_rdata_i = $urandom;
    #1;
    exp_req  = !m_out && !(m_valid && st);
    obs_req  = imem_req_o;
    obs_addr = imem_addr_o;
    check("imem_req", imem_req_o, 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr_o, m_pc);
    check("flush", flush_o, 32'(tk));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      fire = exp_req && gn;
      resp = m_out && rv;
      if (m_valid && !st) m_valid = 0;
      if (resp && m_live && !tk) begin
        m_valid = 1; m_bpc = m_out_pc; m_binstr = imem_rdata_i;
      end
      if (resp) m_out = 0;
      if (fire) begin
        m_out = 1; m_live = 1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
      end
      if (tk) begin
        m_pc = load_target(tg); m_valid = 0; m_live = 0;
      end
      m_mis = tk && (tg[1:0] != 2'b00);
    end
    #1;
    check("if_valid", if_valid_o, 32'(m_valid));
    check("if_pc", if_pc_o, m_bpc);
    check("if_instr", if_instr_o, m_binstr);
`ifdef IF_MISALIGN_CHK_EN
    check("misalign", misalign_o, 32'(m_mis));
`endif
  endtask

  initial begin
    bit          r, tk, st, gn, rv;
    logic [31:0] tg;

    rst = 1; taken_i = 0; target_i = 0; stall_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    @(posedge clk); #1;
    model_reset();
    step(1, 0, 0, 0, 0, 0);
    check("rst_valid", if_valid_o, 32'h0);
    check("rst_pc", if_pc_o, 32'h0);
    check("rst_instr", if_instr_o, 32'h0);

    // Streaming: gnt every cycle, rvalid one cycle after each grant.
    step(0, 0, 0, 0, 1, 0);
    check("seq_addr0", obs_addr, 32'h0);
    step(0, 0, 0, 0, 1, 1);
    check("seq_valid_c2", if_valid_o, 32'h1);
    check("seq_pc0", if_pc_o, 32'h0);
    step(0, 0, 0, 0, 1, 0);
    check("seq_addr4", obs_addr, 32'h4);
    step(0, 0, 0, 0, 1, 1);
    check("seq_pc4", if_pc_o, 32'h4);
    step(0, 0, 0, 0, 1, 0);
    check("seq_addr8", obs_addr, 32'h8);

    // Stall with a full buffer.
    step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 1, 0);
      check("stall_req", 32'(obs_req), 32'h0);
      check("stall_pc", if_pc_o, 32'h8);
    end
    step(0, 0, 0, 0, 1, 0);
    check("stall_resume_req", 32'(obs_req), 32'h1);
    check("stall_resume_addr", obs_addr, 32'hC);

    // Redirect in RESP, stale response three cycles later.
    step(0, 1, 32'h100, 0, 0, 0);
    check("resp_tk_valid", if_valid_o, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("resp_tk_dropped", if_valid_o, 32'h0);
    step(0, 0, 0, 0, 1, 0);
    check("resp_tk_addr", obs_addr, 32'h100);

    // Redirect with grant in REQ, then a redirect while in DROP.
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h200, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("drop_discard", if_valid_o, 32'h0);
    step(0, 0, 0, 0, 1, 0);
    check("drop_addr200", obs_addr, 32'h200);
    step(0, 1, 32'h250, 0, 0, 0);
    step(0, 1, 32'h300, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("drop_addr300", obs_addr, 32'h300);

    // Wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check("wrap_top", obs_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("wrap_zero", obs_addr, 32'h0);

    // Misaligned redirect target.
    step(0, 1, 32'h102, 0, 0, 0);
`ifdef IF_MISALIGN_CHK_EN
    check("misalign_pulse", misalign_o, 32'h1);
    step(0, 0, 0, 0, 0, 0);
    check("misalign_addr", obs_addr, 32'h100);
    check("misalign_clear", misalign_o, 32'h0);
`else
    step(0, 0, 0, 0, 0, 0);
    check("target_unmodified", obs_addr, 32'h102);
`endif

    // Reset mid-request, with a redirect in the reset cycle.
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 32'h500, 0, 0, 0);
    check("rst_tk_valid", if_valid_o, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    check("rst_first_req", 32'(obs_req), 32'h1);
    check("rst_first_addr", obs_addr, 32'h0);

    // Randomized traffic, including spurious rvalid and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(127) == 0);
      tk = ($urandom_range(11) == 0);
      case ($urandom_range(2))
        0:       tg = $urandom & 32'hFFFF_FFFC;
        1:       tg = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: tg = $urandom;
      endcase
      st = ($urandom_range(2) == 0);
      gn = $urandom_range(1) == 1;
      rv = m_out ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
      step(r, tk, tg, st, gn, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_if_fetch
